// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register responder:
// FSM state encodings, response codes and the register map.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_WAIT_DATA = 2'd1,
    W_WAIT_ADDR = 2'd2,
    W_RESP      = 2'd3
  } write_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } read_state_t;

  // Single-bit response encoding used on this bus: 1 = OK, 0 = error.
  localparam logic RESP_OK  = 1'b1;
  localparam logic RESP_ERR = 1'b0;

  localparam int unsigned R0_ADDR = 32'h00;
  localparam int unsigned R1_ADDR = 32'h04;
  localparam int unsigned R2_ADDR = 32'h10;
  localparam int unsigned R3_ADDR = 32'h14;

  localparam int unsigned ALIAS_OFFSET = 8;
  localparam int unsigned ALIAS_BIT    = $clog2(ALIAS_OFFSET);

  localparam int unsigned NUM_REGS = 4;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register
// responder (slave); clock and reset travel as separate scalar ports.
interface axi_lite_reg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decoder: flags word-aligned in-window addresses,
// the read-only alias window, and the register index.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_mapped,
  output logic                  o_alias,
  output logic [1:0]            o_index
);

  logic w_upper_zero;

  generate
    if (ADDR_WIDTH > 5) begin : gen_upper
      assign w_upper_zero = (i_addr[ADDR_WIDTH-1:5] == '0);
    end else begin : gen_no_upper
      assign w_upper_zero = 1'b1;
    end
  endgenerate

  assign o_mapped = (i_addr[1:0] == 2'b00) && w_upper_zero;
  assign o_alias  = i_addr[ALIAS_BIT];
  // addr[4] picks the R0/R1 versus R2/R3 pair, addr[2] the word within it.
  assign o_index  = {i_addr[4], i_addr[2]};

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder with four RW registers and read-only alias windows.
// Write and read channels are independent FSMs with fully registered outputs.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  s0_axi_aclk,
  input  logic                  s0_axi_areset,
  axi_lite_reg_slave_if.slave   s0_axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // ---------------- write channel ----------------
  write_state_t            r_wstate;
  write_state_t            w_wstate_next;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_bvalid;
  logic                    r_bresp;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_commit;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic [STRB_WIDTH-1:0]   w_wr_strb;
  logic                    w_aw_mapped;
  logic                    w_aw_alias;
  logic [1:0]              w_aw_index;
  logic                    w_wr_en;

  assign w_aw_hs = s0_axi.awvalid && r_awready;
  assign w_w_hs  = s0_axi.wvalid  && r_wready;

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wstate_next = W_RESP;
        else if (w_aw_hs)      w_wstate_next = W_WAIT_DATA;
        else if (w_w_hs)       w_wstate_next = W_WAIT_ADDR;
      end
      W_WAIT_DATA: if (w_w_hs)         w_wstate_next = W_RESP;
      W_WAIT_ADDR: if (w_aw_hs)        w_wstate_next = W_RESP;
      W_RESP:      if (s0_axi.bready)  w_wstate_next = W_IDLE;
      default:                         w_wstate_next = W_IDLE;
    endcase
  end

  // The commit edge is the one entering W_RESP; the channel completing the
  // pair on that edge is taken straight from the bus, the other from capture.
  assign w_commit  = (r_wstate != W_RESP) && (w_wstate_next == W_RESP);
  assign w_wr_addr = w_aw_hs ? s0_axi.awaddr : r_awaddr;
  assign w_wr_data = w_w_hs  ? s0_axi.wdata  : r_wdata;
  assign w_wr_strb = w_w_hs  ? s0_axi.wstrb  : r_wstrb;

  axi_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_aw_decode (
    .i_addr   (w_wr_addr),
    .o_mapped (w_aw_mapped),
    .o_alias  (w_aw_alias),
    .o_index  (w_aw_index)
  );

  assign w_wr_en = w_commit && w_aw_mapped && !w_aw_alias;

  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_ERR;
    end else begin
      r_wstate  <= w_wstate_next;
      r_awready <= (w_wstate_next == W_IDLE) || (w_wstate_next == W_WAIT_ADDR);
      r_wready  <= (w_wstate_next == W_IDLE) || (w_wstate_next == W_WAIT_DATA);
      r_bvalid  <= (w_wstate_next == W_RESP);
      if (w_commit) begin
        r_bresp <= w_wr_en ? RESP_OK : RESP_ERR;
      end
    end
  end

  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (w_aw_hs) r_awaddr <= s0_axi.awaddr;
      if (w_w_hs) begin
        r_wdata <= s0_axi.wdata;
        r_wstrb <= s0_axi.wstrb;
      end
    end
  end

  // ---------------- register file ----------------
  logic [DATA_WIDTH-1:0] w_reg_vals [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
      logic [DATA_WIDTH-1:0] r_value;

      always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
        if (s0_axi_areset) begin
          r_value <= '0;
        end else if (w_wr_en && (w_aw_index == 2'(gi))) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_wr_strb[b]) r_value[b*8 +: 8] <= w_wr_data[b*8 +: 8];
          end
        end
      end

      assign w_reg_vals[gi] = r_value;
    end
  endgenerate

  // ---------------- read channel ----------------
  read_state_t           r_rstate;
  read_state_t           w_rstate_next;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_ar_hs;
  logic                  w_ar_mapped;
  logic                  w_ar_alias_unused;
  logic [1:0]            w_ar_index;

  assign w_ar_hs = s0_axi.arvalid && r_arready;

  // Aliases read back the same register, so the alias flag plays no part here.
  axi_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_ar_decode (
    .i_addr   (s0_axi.araddr),
    .o_mapped (w_ar_mapped),
    .o_alias  (w_ar_alias_unused),
    .o_index  (w_ar_index)
  );

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)       w_rstate_next = R_DATA;
      R_DATA:  if (s0_axi.rready) w_rstate_next = R_IDLE;
      default:                    w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_ERR;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rstate_next;
      r_arready <= (w_rstate_next == R_IDLE);
      r_rvalid  <= (w_rstate_next == R_DATA);
      // Sampling the register file here yields the pre-write value when a
      // write commits to the same register on this edge.
      if (w_ar_hs) begin
        r_rdata <= w_ar_mapped ? w_reg_vals[w_ar_index] : '0;
        r_rresp <= w_ar_mapped ? RESP_OK : RESP_ERR;
      end
    end
  end

  assign s0_axi.awready = r_awready;
  assign s0_axi.wready  = r_wready;
  assign s0_axi.bvalid  = r_bvalid;
  assign s0_axi.bresp   = r_bresp;
  assign s0_axi.arready = r_arready;
  assign s0_axi.rvalid  = r_rvalid;
  assign s0_axi.rresp   = r_rresp;
  assign s0_axi.rdata   = r_rdata;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with a register model and response
// scoreboards; every check is an immediate assertion.
module tb_axi_lite_reg_slave;
  import axi_lite_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8;
  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          resp;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_lite_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .s0_axi_aclk   (clk),
    .s0_axi_areset (rst),
    .s0_axi        (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] m_regs [4];
  logic  exp_b [$];
  rexp_t exp_r [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mapped(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && (a[AW-1:5] == '0);
  endfunction

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [1:0] idx;
    idx = {a[4], a[2]};
    if (is_mapped(a) && !a[3]) begin
      exp_b.push_back(RESP_OK);
      for (int i = 0; i < SW; i++) if (s[i]) m_regs[idx][i*8 +: 8] = d[i*8 +: 8];
    end else begin
      exp_b.push_back(RESP_ERR);
    end
  endtask

  task automatic push_read(input logic [AW-1:0] a);
    rexp_t e;
    logic [1:0] idx;
    idx = {a[4], a[2]};
    if (is_mapped(a)) begin
      e.data = m_regs[idx];
      e.resp = RESP_OK;
    end else begin
      e.data = '0;
      e.resp = RESP_ERR;
    end
    exp_r.push_back(e);
  endtask

  task automatic aw_send(input logic [AW-1:0] a);
    int n = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (n >= TIMEOUT) check("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (n >= TIMEOUT) check("w_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic aw_w_send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    while (!(bus.awready === 1'b1 && bus.wready === 1'b1) && n < TIMEOUT) begin
      @(posedge clk); #1; n++;
    end
    if (n >= TIMEOUT) check("aw_w_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [AW-1:0] a);
    int n = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (n >= TIMEOUT) check("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic b_collect();
    int n = 0;
    logic e;
    while (bus.bvalid !== 1'b1 && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (n >= TIMEOUT) check("bvalid_timeout", 64'd0, 64'd1);
    if (exp_b.size() == 0) begin
      check("b_scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_b.pop_front();
      check("bresp", 64'(bus.bresp), 64'(e));
      $display("B  resp=%0d expected=%0d", bus.bresp, e);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("bvalid_drop", 64'(bus.bvalid), 64'd0);
  endtask

  task automatic r_collect();
    int n = 0;
    rexp_t e;
    while (bus.rvalid !== 1'b1 && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (n >= TIMEOUT) check("rvalid_timeout", 64'd0, 64'd1);
    if (exp_r.size() == 0) begin
      check("r_scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_r.pop_front();
      check("rdata", 64'(bus.rdata), 64'(e.data));
      check("rresp", 64'(bus.rresp), 64'(e.resp));
      $display("R  data=%08h resp=%0d expected=%08h/%0d", bus.rdata, bus.rresp, e.data, e.resp);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check("rvalid_drop", 64'(bus.rvalid), 64'd0);
  endtask

  // skew > 0: AW leads W by skew cycles; skew < 0: W leads AW.
  task automatic write_tx(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int skew);
    $display("W  addr=%02h data=%08h strb=%0h skew=%0d", a, d, s, skew);
    push_write(a, d, s);
    if (skew == 0) begin
      aw_w_send(a, d, s);
    end else if (skew > 0) begin
      aw_send(a);
      check("awready_after_aw", 64'(bus.awready), 64'd0);
      repeat (skew - 1) begin @(posedge clk); #1; end
      check("bvalid_before_w", 64'(bus.bvalid), 64'd0);
      w_send(d, s);
    end else begin
      w_send(d, s);
      check("wready_after_w", 64'(bus.wready), 64'd0);
      repeat (-skew - 1) begin @(posedge clk); #1; end
      check("bvalid_before_aw", 64'(bus.bvalid), 64'd0);
      aw_send(a);
    end
    check("bvalid_latency", 64'(bus.bvalid), 64'd1);
    b_collect();
  endtask

  task automatic read_tx(input logic [AW-1:0] a);
    $display("AR addr=%02h", a);
    push_read(a);
    ar_send(a);
    check("rvalid_latency", 64'(bus.rvalid), 64'd1);
    r_collect();
  endtask

  initial begin
    rexp_t hold_r;
    logic  hold_b;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_wready",  64'(bus.wready),  64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_bvalid",  64'(bus.bvalid),  64'd0);
    check("rst_rvalid",  64'(bus.rvalid),  64'd0);
    check("rst_bresp",   64'(bus.bresp),   64'd0);
    check("rst_rresp",   64'(bus.rresp),   64'd0);
    check("rst_rdata",   64'(bus.rdata),   64'd0);
    rst = 1'b0;
    check("rdy_before_edge", 64'(bus.awready), 64'd0);
    @(posedge clk); #1;
    check("awready_release", 64'(bus.awready), 64'd1);
    check("wready_release",  64'(bus.wready),  64'd1);
    check("arready_release", 64'(bus.arready), 64'd1);

    // Basic write and alias read-back
    write_tx(AW'(R0_ADDR), 32'hDEADBEEF, 4'hF, 0);
    read_tx(AW'(R0_ADDR + ALIAS_OFFSET));

    // Channel skew both ways
    write_tx(AW'(R3_ADDR), 32'h12345678, 4'hF, 3);
    read_tx(AW'(R3_ADDR));
    write_tx(AW'(R1_ADDR), 32'h12345678, 4'hF, -3);
    read_tx(AW'(R1_ADDR));
    read_tx(AW'(R3_ADDR + ALIAS_OFFSET));

    // Byte strobes, including the empty strobe
    write_tx(AW'(R2_ADDR), 32'hFFFFFFFF, 4'hF, 0);
    write_tx(AW'(R2_ADDR), 32'h00000000, 4'h5, 0);
    read_tx(AW'(R2_ADDR));
    write_tx(AW'(R2_ADDR), 32'h13579BDF, 4'h0, 0);
    read_tx(AW'(R2_ADDR));

    // Error responses
    write_tx(8'h08, 32'h11111111, 4'hF, 0);
    read_tx(AW'(R0_ADDR));
    write_tx(8'h02, 32'h22222222, 4'hF, 0);
    read_tx(8'h40);
    read_tx(8'h06);

    // Read handshake on the same edge as a write commit to that register
    $display("RW concurrent addr=00");
    push_read(8'h00);
    push_write(8'h00, 32'hA5A5A5A5, 4'hF);
    bus.araddr = 8'h00; bus.arvalid = 1'b1;
    aw_w_send(8'h00, 32'hA5A5A5A5, 4'hF);
    bus.arvalid = 1'b0;
    b_collect();
    r_collect();
    read_tx(8'h00);

    // Backpressure on both response channels
    $display("Backpressure addr=04");
    push_write(AW'(R1_ADDR), 32'hCAFEF00D, 4'hF);
    aw_w_send(AW'(R1_ADDR), 32'hCAFEF00D, 4'hF);
    push_read(AW'(R1_ADDR + ALIAS_OFFSET));
    ar_send(AW'(R1_ADDR + ALIAS_OFFSET));
    hold_b = exp_b[0];
    hold_r = exp_r[0];
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_bvalid",  64'(bus.bvalid),  64'd1);
      check("bp_bresp",   64'(bus.bresp),   64'(hold_b));
      check("bp_rvalid",  64'(bus.rvalid),  64'd1);
      check("bp_rdata",   64'(bus.rdata),   64'(hold_r.data));
      check("bp_rresp",   64'(bus.rresp),   64'(hold_r.resp));
      check("bp_awready", 64'(bus.awready), 64'd0);
      check("bp_wready",  64'(bus.wready),  64'd0);
      check("bp_arready", 64'(bus.arready), 64'd0);
    end
    b_collect();
    r_collect();

    // Reset while a write response is pending
    $display("Reset in W_RESP");
    push_write(AW'(R2_ADDR), 32'h0BADF00D, 4'hF);
    aw_w_send(AW'(R2_ADDR), 32'h0BADF00D, 4'hF);
    check("pre_rst_bvalid", 64'(bus.bvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_bvalid", 64'(bus.bvalid),  64'd0);
    check("async_awready", 64'(bus.awready), 64'd0);
    check("async_arready", 64'(bus.arready), 64'd0);
    exp_b.delete();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rdy_held_after_release", 64'(bus.wready), 64'd0);
    @(posedge clk); #1;
    check("awready_rerelease", 64'(bus.awready), 64'd1);
    check("wready_rerelease",  64'(bus.wready),  64'd1);
    check("arready_rerelease", 64'(bus.arready), 64'd1);
    check("no_stale_bvalid",   64'(bus.bvalid),  64'd0);
    read_tx(AW'(R0_ADDR));
    read_tx(AW'(R1_ADDR));
    read_tx(AW'(R2_ADDR));
    read_tx(AW'(R3_ADDR));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite responder holding four RW registers plus read-only alias windows. It sits on the m1 side of the interconnect and answers its write and read traffic. Write and read channels run independent FSMs, each with one transaction in flight. The alias windows give the interconnect a loopback path: write 0x00, then read 0x08 to get the same value.

## Interface
- DATA_WIDTH, 32: data bus width; must be a multiple of 8.
- ADDR_WIDTH, 8: byte address width; minimum 5.
- s0_axi_aclk  in  1  clock; all logic is on the rising edge.
- s0_axi_areset  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- s0_axi_awaddr  in  ADDR_WIDTH  write address.
- s0_axi_awvalid  in  1 / s0_axi_awready  out  1  write address handshake.
- s0_axi_wdata  in  DATA_WIDTH  write data.
- s0_axi_wstrb  in  DATA_WIDTH/8  byte-lane enables.
- s0_axi_wvalid  in  1 / s0_axi_wready  out  1  write data handshake.
- s0_axi_bresp  out  1  write response; 1 = OK, 0 = error.
- s0_axi_bvalid  out  1 / s0_axi_bready  in  1  write response handshake.
- s0_axi_araddr  in  ADDR_WIDTH  read address.
- s0_axi_arvalid  in  1 / s0_axi_arready  out  1  read address handshake.
- s0_axi_rdata  out  DATA_WIDTH  read data.
- s0_axi_rresp  out  1  read response; 1 = OK, 0 = error.
- s0_axi_rvalid  out  1 / s0_axi_rready  in  1  read data handshake.

## Operation
- Register map:
  - R0 at 0x00, R1 at 0x04, R2 at 0x10, R3 at 0x14; all RW, reset 0.
  - Aliases at 0x08/0x0C/0x18/0x1C are read-only and return R0/R1/R2/R3.
- Decode:
  - Address is mapped iff addr[1:0]==0 and addr[ADDR_WIDTH-1:5]==0.
  - Register index = {addr[4], addr[2]}; addr[3]=1 selects the alias window.
- Write FSM:
  - W_IDLE (awready=1, wready=1).
  - On AW-only handshake → W_WAIT_DATA (awready=0, wready=1).
  - On W-only handshake → W_WAIT_ADDR (awready=1, wready=0).
  - On both handshakes in the same cycle → W_RESP.
  - Leave W_WAIT_* → W_RESP when the missing channel handshakes.
  - W_RESP (bvalid=1, both readys 0) → W_IDLE on bready.
- Write commit:
  - Happens on the edge that completes the AW+W pair.
  - Byte lane i of the selected register updates iff wstrb[i]; wstrb=0 is legal, leaves the register unchanged, and returns bresp=1.
  - Write to an alias or unmapped address: no register change, bresp=0.
- Read FSM:
  - R_IDLE (arready=1).
  - On AR handshake, latch rdata/rresp → R_DATA (arready=0, rvalid=1).
  - R_DATA → R_IDLE on rready.
- Read results:
  - Mapped address: rdata = register value, rresp=1.
  - Unmapped address: rdata=0, rresp=0.
- Read and write run concurrently. If a read handshake and a write commit to the same register fall on the same edge, the read returns the pre-write value.

## Timing
- Reset (async assert; deassert synchronised externally):
  - All readys 0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, R0–R3=0, both FSMs in IDLE.
  - awready, wready and arready go to 1 on the first rising edge after deassertion.
- All outputs are registered; there is no combinational path from any input to any output.
- Write latency: the AW+W completing handshake at edge N gives bvalid=1 and the register updated after edge N. Next AW/W acceptance is possible at edge N+2 at the earliest, with bready held high.
- Read latency: AR handshake at edge N gives rvalid=1 with data after edge N. Sustained throughput is one read per 2 cycles.
- bvalid/rvalid, once asserted, are held with stable resp/data until their ready is sampled high.
- Reset mid-transaction aborts it. No response is issued afterwards, and a partially captured AW or W is discarded.

## Structure
- axi_lite_pkg holds:
  - write_state_t {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} and read_state_t {R_IDLE, R_DATA};
  - RESP_OK=1'b1 and RESP_ERR=1'b0;
  - address constants R0_ADDR..R3_ADDR and the ALIAS_OFFSET=8 constant.
- The purely combinational decoder axi_lite_addr_decode (address → mapped, alias, index) is a natural sub-module. It is instantiated twice, once for AW and once for AR.

## Test plan
- Basic write then alias read: AW 0x00 + W 0xDEADBEEF, wstrb 0xF, in the same cycle → bvalid one cycle later, bresp=1. Then read 0x08 → rdata 0xDEADBEEF, rresp=1.
- Channel skew: AW 0x14 is presented 3 cycles before W 0x12345678.
  - awready drops after the AW handshake; bvalid rises only after the W handshake.
  - Read 0x14 → 0x12345678. Repeat with W leading AW; same result.
- Byte strobes: R2=0xFFFFFFFF, then write 0x00000000 with wstrb=0x5 → read 0x10 returns 0xFF00FF00.
- Errors:
  - Write to 0x08 → bresp=0 and R0 unchanged.
  - Write to 0x02 → bresp=0.
  - Read 0x40 → rdata=0, rresp=0.
- Backpressure: hold bready=0 and rready=0 for 5 cycles → bvalid/rvalid, bresp/rresp and rdata stay stable, and no new AW/W/AR is accepted.
- Reset mid-operation: assert reset while in W_RESP → bvalid=0 immediately (asynchronously), all registers read 0 afterwards, and readys return to 1 on the first edge after release.
